// File: rtl/module_codif_hamming.sv
// SECDED Hamming(7,4)+p0 encoder with valid/ready handshake
// and a small output FIFO; err_mask corrupts words as they are stored.
module module_codif_hamming #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       datos_in,
    input  logic [7:0]       err_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       datos_cod,
    output logic [CNT_W-1:0] palabras_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [7:0]  encoded;

    always_comb begin
        encoded    = 8'h00;
        encoded[2] = datos_in[0];
        encoded[4] = datos_in[1];
        encoded[5] = datos_in[2];
        encoded[6] = datos_in[3];
        encoded[0] = datos_in[0] ^ datos_in[1] ^ datos_in[3];
        encoded[1] = datos_in[0] ^ datos_in[2] ^ datos_in[3];
        encoded[3] = datos_in[1] ^ datos_in[2] ^ datos_in[3];
        encoded[7] = ^encoded[6:0];
    end

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset; the empty flag masks any stale head.
    assign datos_cod = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= encoded ^ err_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            palabras_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + (AW+1)'(1);
                palabras_cnt <= palabras_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_module_codif_hamming.sv
// Self-checking bench for module_codif_hamming: directed scenarios
// plus randomized traffic against a queue-based reference model.
module tb_module_codif_hamming;

    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    datos_in = 4'h0;
    logic [7:0]    err_mask = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    datos_cod;
    logic [CW-1:0] palabras_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0]    q[$];
    logic [CW-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    module_codif_hamming #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .datos_in(datos_in),
        .err_mask(err_mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .datos_cod(datos_cod),
        .palabras_cnt(palabras_cnt)
    );

    // Classic Hamming: code position n = bit n-1; parity at 2^k covers
    // every position with bit k set; bit7 makes total parity even.
    function automatic logic [7:0] ref_enc(input logic [3:0] d);
        logic [7:0] c;
        int dpos[4];
        logic p;
        c = 8'h00;
        dpos = '{3, 5, 6, 7};
        for (int i = 0; i < 4; i++) c[dpos[i]-1] = d[i];
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int n = 1; n < 8; n++)
                if (((n >> k) & 1) == 1 && n != (1 << k)) p = p ^ c[n-1];
            c[(1 << k) - 1] = p;
        end
        c[7] = ^c[6:0];
        return c;
    endfunction

    function automatic int syndrome(input logic [7:0] c);
        int s;
        s = 0;
        for (int n = 1; n < 8; n++) if (c[n-1]) s = s ^ n;
        return s;
    endfunction

    function automatic logic [3:0] extract(input logic [7:0] c);
        return {c[6], c[5], c[4], c[2]};
    endfunction

    task automatic step();
        bit push, pop;
        logic [7:0] w;
        push = in_valid && (q.size() < DEPTH) && !rst;
        pop  = out_ready && (q.size() > 0) && !rst;
        w = ref_enc(datos_in) ^ err_mask;
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_cnt = '0;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                exp_cnt = exp_cnt + 1'b1;
            end
            if (push) q.push_back(w);
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        err_mask = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || datos_cod !== 8'h00 ||
            palabras_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: ov=%b cod=%h cnt=%0d ir=%b want 0 00 0 1",
                     out_valid, datos_cod, palabras_cnt, in_ready);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        datos_in = 4'hB;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || datos_cod !== 8'h55) begin
            errors++;
            $display("FAIL basic_out: ov=%b cod=%h want 1 55",
                     out_valid, datos_cod);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || palabras_cnt !== 16'd1) begin
            errors++;
            $display("FAIL basic_drain: ov=%b cnt=%0d want 0 1",
                     out_valid, palabras_cnt);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] fixed[4];
        logic [3:0] fin[4];
        fixed = '{8'h00, 8'h87, 8'h55, 8'hFF};
        fin = '{4'h0, 4'h1, 4'hB, 4'hF};
        apply_reset();
        out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            datos_in = v[3:0];
            in_valid = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b1 || datos_cod !== ref_enc(v[3:0])) begin
                errors++;
                $display("FAIL sweep_%0d: ov=%b cod=%h want 1 %h",
                         v, out_valid, datos_cod, ref_enc(v[3:0]));
            end
            checks++;
            if ((^datos_cod) !== 1'b0 || syndrome(datos_cod) != 0 ||
                extract(datos_cod) !== v[3:0]) begin
                errors++;
                $display("FAIL sweep_dec_%0d: cod=%h syn=%0d want even,0,%h",
                         v, datos_cod, syndrome(datos_cod), v[3:0]);
            end
            for (int j = 0; j < 4; j++) begin
                if (fin[j] == v[3:0]) begin
                    checks++;
                    if (datos_cod !== fixed[j]) begin
                        errors++;
                        $display("FAIL sweep_const_%0d: cod=%h want %h",
                                 v, datos_cod, fixed[j]);
                    end
                end
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || palabras_cnt !== 16'd16) begin
            errors++;
            $display("FAIL sweep_end: ov=%b cnt=%0d want 0 16",
                     out_valid, palabras_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] w[5];
        int k;
        for (int i = 0; i < 5; i++) w[i] = 4'($urandom_range(0, 15));
        apply_reset();
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (in_ready !== (k < 4)) begin
                errors++;
                $display("FAIL bp_ready_%0d: ir=%b want %b", c, in_ready, k < 4);
            end
            datos_in = w[k];
            in_valid = 1'b1;
            if (in_ready === 1'b1 && k < 4) k++;
            step();
        end
        out_ready = 1'b1;
        datos_in = w[4];
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || datos_cod !== ref_enc(w[i])) begin
                errors++;
                $display("FAIL bp_order_%0d: ov=%b cod=%h want 1 %h",
                         i, out_valid, datos_cod, ref_enc(w[i]));
            end
            if (in_ready === 1'b1) begin
                step();
                in_valid = 1'b0;
            end else begin
                step();
            end
        end
        checks++;
        if (out_valid !== 1'b0 || palabras_cnt !== 16'd5) begin
            errors++;
            $display("FAIL bp_cnt: ov=%b cnt=%0d want 0 5",
                     out_valid, palabras_cnt);
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] sent[$];
        int got;
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            datos_in = 4'($urandom_range(0, 15));
            sent.push_back(ref_enc(datos_in));
            step();
        end
        got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            datos_in = 4'($urandom_range(0, 15));
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 ||
                datos_cod !== sent[got]) begin
                errors++;
                $display("FAIL pp_%0d: ov=%b ir=%b cod=%h want 1 1 %h",
                         c, out_valid, in_ready, datos_cod, sent[got]);
            end
            sent.push_back(ref_enc(datos_in));
            got++;
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_valid !== 1'b1 || datos_cod !== sent[got]) begin
                errors++;
                $display("FAIL pp_tail_%0d: ov=%b cod=%h want 1 %h",
                         c, out_valid, datos_cod, sent[got]);
            end
            got++;
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || palabras_cnt !== 16'd12) begin
            errors++;
            $display("FAIL pp_end: ov=%b cnt=%0d want 0 12",
                     out_valid, palabras_cnt);
        end
    endtask

    task automatic test_err_mask();
        logic [7:0] masks[2];
        logic [7:0] want[2];
        masks = '{8'h04, 8'h80};
        want = '{8'h51, 8'hD5};
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            datos_in = 4'hB;
            err_mask = masks[i];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            err_mask = 8'h00;
            checks++;
            if (out_valid !== 1'b1 || datos_cod !== want[i]) begin
                errors++;
                $display("FAIL errmask_%0d: ov=%b cod=%h want 1 %h",
                         i, out_valid, datos_cod, want[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            datos_in = 4'(i + 5);
            step();
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: ov=%b want 1", out_valid);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || datos_cod !== 8'h00 ||
            palabras_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst: ov=%b cod=%h cnt=%0d ir=%b want 0 00 0 1",
                     out_valid, datos_cod, palabras_cnt, in_ready);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || palabras_cnt !== '0) begin
                errors++;
                $display("FAIL mid_stale_%0d: ov=%b cnt=%0d want 0 0",
                         c, out_valid, palabras_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] head;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            datos_in = 4'($urandom_range(0, 15));
            err_mask = ($urandom_range(0, 7) == 0) ?
                       8'(1 << $urandom_range(0, 7)) : 8'h00;
            head = (q.size() > 0) ? q[0] : 8'h00;
            checks++;
            if (in_ready !== (q.size() < DEPTH) ||
                out_valid !== (q.size() > 0) ||
                datos_cod !== head || palabras_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL rand_%0d: ir=%b ov=%b cod=%h cnt=%0d want %b %b %h %0d",
                         c, in_ready, out_valid, datos_cod, palabras_cnt,
                         q.size() < DEPTH, q.size() > 0, head, exp_cnt);
            end
            step();
        end
        in_valid = 1'b0;
        err_mask = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_backpressure();
        test_push_pop();
        test_err_mask();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
